hyper_mvblck_frdram: RTL and testbench

Block mover from DRAM into an LSAB section, the read-direction counterpart of the LSAB-to-DRAM mover. The driver issues a start address, word count, LSAB section and DRAM select. The block issues paired-word MCU read requests, credit-checked against LSAB free space. It strobes LSAB_WRITE in step with the fixed MCU read-data latency. The data path runs MCU→LSAB directly; this block only sequences control.

---
 rtl/hyper_mvblck_frdram.sv | 155 +++++++++++++++
 tb/tb_hyper_mvblck_frdram.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_mvblck_frdram.sv
// DRAM-to-LSAB block mover: sequences paired-word MCU reads, credit-checked against
// LSAB free space, and strobes LSAB_WRITE in step with the fixed MCU read latency.
module hyper_mvblck_frdram #(
  parameter int RD_LATENCY = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [5:0]  LSAB_0_SPACE,
  input  logic [5:0]  LSAB_1_SPACE,
  input  logic [5:0]  LSAB_2_SPACE,
  input  logic [5:0]  LSAB_3_SPACE,
  output logic        LSAB_WRITE,
  output logic [1:0]  LSAB_SECTION,
  output logic        LSAB_LAST,
  input  logic [11:0] START_ADDRESS,
  input  logic [5:0]  COUNT_REQ,
  input  logic [1:0]  SECTION,
  input  logic [1:0]  DRAM_SEL,
  input  logic        ISSUE,
  input  logic        CANCEL,
  output logic [5:0]  COUNT_SENT,
  output logic        WORKING,
  output logic        IRQ_OUT,
  output logic        ABRUPT_STOP,
  output logic [11:0] MCU_COLL_ADDRESS,
  output logic [3:0]  MCU_WE_ARRAY,
  output logic [1:0]  MCU_REQUEST_ACCESS
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_GAP, S_DRAIN, S_DONE} state_t;

  state_t      state_reg, state_next;
  logic [11:0] track_addr_reg;
  logic [5:0]  remaining_reg;
  logic [5:0]  count_req_reg;
  logic [1:0]  dram_sel_reg;
  logic [6:0]  inflight_reg;
  logic [5:0]  written_reg;
  logic        cancelled_reg;
  logic        busy_reg;
  logic [RD_LATENCY:0]   even_pipe_reg;
  logic [RD_LATENCY+1:0] odd_pipe_reg;

  logic [5:0]  space_sel;
  logic        even_ok, odd_ok, can_issue, issue_req, accept;
  logic [6:0]  need_w;
  logic [5:0]  rem_after;
  logic [11:0] pair_addr;

  always_comb begin
    space_sel = LSAB_0_SPACE;
    case (LSAB_SECTION)
      2'd0: space_sel = LSAB_0_SPACE;
      2'd1: space_sel = LSAB_1_SPACE;
      2'd2: space_sel = LSAB_2_SPACE;
      2'd3: space_sel = LSAB_3_SPACE;
      default: space_sel = LSAB_0_SPACE;
    endcase
  end

  assign pair_addr = {track_addr_reg[11:1], 1'b0};
  assign even_ok   = ~track_addr_reg[0] && (remaining_reg != 6'd0);
  assign odd_ok    = even_ok ? (remaining_reg >= 6'd2) : (remaining_reg >= 6'd1);
  assign need_w    = {6'd0, even_ok} + {6'd0, odd_ok};
  assign rem_after = remaining_reg - need_w[5:0];
  assign can_issue = {1'b0, space_sel} >= (inflight_reg + need_w);
  assign issue_req = (state_reg == S_REQ) && !CANCEL && can_issue;
  assign accept    = (state_reg == S_IDLE) && ISSUE;

  // Even word returns RD_LATENCY cycles after the visible request, odd word one later.
  assign LSAB_WRITE   = even_pipe_reg[RD_LATENCY] | odd_pipe_reg[RD_LATENCY+1];
  assign LSAB_LAST    = LSAB_WRITE && !cancelled_reg && ((written_reg + 6'd1) == count_req_reg);
  assign MCU_WE_ARRAY = 4'b0000;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (ISSUE) state_next = (COUNT_REQ == 6'd0) ? S_DONE : S_REQ;
      S_REQ: begin
        if (CANCEL)         state_next = S_DRAIN;
        else if (can_issue) state_next = (rem_after == 6'd0) ? S_DRAIN : S_GAP;
      end
      S_GAP:   state_next = CANCEL ? S_DRAIN : S_REQ;
      S_DRAIN: if (inflight_reg == 7'd0) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      track_addr_reg     <= '0;
      remaining_reg      <= '0;
      count_req_reg      <= '0;
      dram_sel_reg       <= '0;
      inflight_reg       <= '0;
      written_reg        <= '0;
      cancelled_reg      <= 1'b0;
      busy_reg           <= 1'b0;
      even_pipe_reg      <= '0;
      odd_pipe_reg       <= '0;
      LSAB_SECTION       <= '0;
      COUNT_SENT         <= '0;
      WORKING            <= 1'b0;
      IRQ_OUT            <= 1'b0;
      ABRUPT_STOP        <= 1'b0;
      MCU_COLL_ADDRESS   <= '0;
      MCU_REQUEST_ACCESS <= '0;
    end else begin
      even_pipe_reg      <= {even_pipe_reg[RD_LATENCY-1:0], issue_req & even_ok};
      odd_pipe_reg       <= {odd_pipe_reg[RD_LATENCY:0], issue_req & odd_ok};
      inflight_reg       <= inflight_reg + (issue_req ? need_w : 7'd0) - {6'd0, LSAB_WRITE};
      MCU_REQUEST_ACCESS <= issue_req ? dram_sel_reg : 2'b00;
      MCU_COLL_ADDRESS   <= issue_req ? pair_addr : 12'd0;
      WORKING            <= busy_reg;
      IRQ_OUT            <= (state_next == S_DONE);

      if (accept) begin
        track_addr_reg <= START_ADDRESS;
        remaining_reg  <= COUNT_REQ;
        count_req_reg  <= COUNT_REQ;
        dram_sel_reg   <= DRAM_SEL;
        LSAB_SECTION   <= SECTION;
        written_reg    <= '0;
        cancelled_reg  <= 1'b0;
        busy_reg       <= 1'b1;
      end else begin
        if (LSAB_WRITE) written_reg <= written_reg + 6'd1;
        if (issue_req) begin
          track_addr_reg <= pair_addr + 12'd2;
          remaining_reg  <= rem_after;
        end
        if (CANCEL && (state_reg == S_REQ || state_reg == S_GAP)) cancelled_reg <= 1'b1;
        if (state_reg == S_DONE) busy_reg <= 1'b0;
      end

      // Completion results are captured on the way into DONE so they are valid with IRQ_OUT.
      if (state_next == S_DONE) begin
        if (state_reg == S_IDLE) begin
          COUNT_SENT  <= 6'd0;
          ABRUPT_STOP <= 1'b0;
        end else begin
          COUNT_SENT  <= written_reg;
          ABRUPT_STOP <= (written_reg != count_req_reg);
        end
      end
    end
  end

endmodule

// File: tb/tb_hyper_mvblck_frdram.sv
// Scoreboard bench for hyper_mvblck_frdram: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares requests, write strobes and completions.
module tb_hyper_mvblck_frdram;
  localparam int L = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [5:0]  LSAB_0_SPACE = 6'd63, LSAB_1_SPACE = 6'd63, LSAB_2_SPACE = 6'd63, LSAB_3_SPACE = 6'd63;
  logic        LSAB_WRITE, LSAB_LAST;
  logic [1:0]  LSAB_SECTION;
  logic [11:0] START_ADDRESS = '0;
  logic [5:0]  COUNT_REQ = '0;
  logic [1:0]  SECTION = '0, DRAM_SEL = '0;
  logic        ISSUE = 1'b0, CANCEL = 1'b0;
  logic [5:0]  COUNT_SENT;
  logic        WORKING, IRQ_OUT, ABRUPT_STOP;
  logic [11:0] MCU_COLL_ADDRESS;
  logic [3:0]  MCU_WE_ARRAY;
  logic [1:0]  MCU_REQUEST_ACCESS;

  hyper_mvblck_frdram #(.RD_LATENCY(L)) dut (
    .CLK(CLK), .RST(RST),
    .LSAB_0_SPACE(LSAB_0_SPACE), .LSAB_1_SPACE(LSAB_1_SPACE),
    .LSAB_2_SPACE(LSAB_2_SPACE), .LSAB_3_SPACE(LSAB_3_SPACE),
    .LSAB_WRITE(LSAB_WRITE), .LSAB_SECTION(LSAB_SECTION), .LSAB_LAST(LSAB_LAST),
    .START_ADDRESS(START_ADDRESS), .COUNT_REQ(COUNT_REQ), .SECTION(SECTION),
    .DRAM_SEL(DRAM_SEL), .ISSUE(ISSUE), .CANCEL(CANCEL),
    .COUNT_SENT(COUNT_SENT), .WORKING(WORKING), .IRQ_OUT(IRQ_OUT),
    .ABRUPT_STOP(ABRUPT_STOP), .MCU_COLL_ADDRESS(MCU_COLL_ADDRESS),
    .MCU_WE_ARRAY(MCU_WE_ARRAY), .MCU_REQUEST_ACCESS(MCU_REQUEST_ACCESS)
  );

  always #5 CLK = ~CLK;

  typedef struct {logic [11:0] addr; logic [1:0] sel; logic [1:0] mask; int gap;} req_t;
  typedef struct {logic [5:0] cnt; logic abrupt;} done_t;

  req_t  exp_req_q[$];
  done_t exp_done_q[$];
  int    due_q[$];
  bit    exp_last_q[$];

  int errors = 0, checks = 0;
  int cyc = 0, last_req_cyc = 0, done_seen = 0, done_mark = 0;
  int writes_seen = 0, words_req = 0;
  bit stall_chk = 0;
  logic [1:0] exp_section = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen with nothing expected (cycle %0d)", name, cyc);
  endtask

  always @(posedge CLK) cyc++;

  // Monitor
  always @(negedge CLK) begin
    if (RST) begin
      if (MCU_REQUEST_ACCESS != 2'b00) begin
        if (exp_req_q.size() == 0) fail_now("unexpected_req");
        else begin
          req_t r;
          r = exp_req_q.pop_front();
          chk("req_addr", MCU_COLL_ADDRESS, r.addr);
          chk("req_sel", MCU_REQUEST_ACCESS, r.sel);
          if (r.gap > 0) chk("req_spacing", cyc - last_req_cyc, r.gap);
          if (stall_chk) chk("req_credit_stall", writes_seen, words_req);
          words_req += int'(r.mask[1]) + int'(r.mask[0]);
          if (r.mask[1]) due_q.push_back(cyc + L);
          if (r.mask[0]) due_q.push_back(cyc + L + 1);
          $display("req  addr=%03h sel=%0d mask=%b cycle=%0d", MCU_COLL_ADDRESS, MCU_REQUEST_ACCESS, r.mask, cyc);
        end
        chk("we_array", MCU_WE_ARRAY, 4'b0000);
        last_req_cyc = cyc;
      end
      if (LSAB_WRITE) begin
        if (due_q.size() == 0) fail_now("unexpected_write");
        else chk("write_cycle", cyc, due_q.pop_front());
        if (exp_last_q.size() == 0) fail_now("unexpected_write_last");
        else chk("lsab_last", LSAB_LAST, exp_last_q.pop_front());
        chk("lsab_section", LSAB_SECTION, exp_section);
        writes_seen++;
        $display("wr   section=%0d last=%0b cycle=%0d", LSAB_SECTION, LSAB_LAST, cyc);
      end else if (LSAB_LAST) fail_now("last_without_write");
      if (IRQ_OUT) begin
        if (exp_done_q.size() == 0) fail_now("unexpected_irq");
        else begin
          done_t d;
          d = exp_done_q.pop_front();
          chk("count_sent", COUNT_SENT, d.cnt);
          chk("abrupt_stop", ABRUPT_STOP, d.abrupt);
        end
        done_seen++;
        $display("done count_sent=%0d abrupt=%0b cycle=%0d", COUNT_SENT, ABRUPT_STOP, cyc);
      end
    end
  end

  task automatic push_req(input logic [11:0] a, input logic [1:0] s, input logic [1:0] m, input int g);
    req_t r;
    r.addr = a; r.sel = s; r.mask = m; r.gap = g;
    exp_req_q.push_back(r);
  endtask

  task automatic push_done(input logic [5:0] c, input logic ab, input int n_words);
    done_t d;
    d.cnt = c; d.abrupt = ab;
    exp_done_q.push_back(d);
    for (int i = 0; i < n_words; i++) exp_last_q.push_back(i == n_words - 1 && !ab);
  endtask

  task automatic start_xfer(input logic [11:0] a, input logic [5:0] c, input logic [1:0] sec, input logic [1:0] sel);
    @(posedge CLK); #1;
    START_ADDRESS = a; COUNT_REQ = c; SECTION = sec; DRAM_SEL = sel;
    exp_section = sec;
    done_mark = done_seen;
    ISSUE = 1'b1;
    @(posedge CLK); #1;
    ISSUE = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 300; i++) begin
      if (done_seen != done_mark) break;
      @(posedge CLK); #1;
    end
    chk({name, "_completed"}, done_seen != done_mark, 1);
    repeat (3) @(posedge CLK);
    #1;
    chk({name, "_req_q_empty"}, exp_req_q.size(), 0);
    chk({name, "_write_q_empty"}, due_q.size(), 0);
    chk({name, "_last_q_empty"}, exp_last_q.size(), 0);
    chk({name, "_working_low"}, WORKING, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_write"}, LSAB_WRITE, 0);
    chk({tag, "_last"}, LSAB_LAST, 0);
    chk({tag, "_section"}, LSAB_SECTION, 0);
    chk({tag, "_count_sent"}, COUNT_SENT, 0);
    chk({tag, "_working"}, WORKING, 0);
    chk({tag, "_irq"}, IRQ_OUT, 0);
    chk({tag, "_abrupt"}, ABRUPT_STOP, 0);
    chk({tag, "_addr"}, MCU_COLL_ADDRESS, 0);
    chk({tag, "_req"}, MCU_REQUEST_ACCESS, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk_zero("rst_hold");
    RST = 1'b1;
    @(posedge CLK); #1;
    chk_zero("rst_release");

    // 1: aligned, count 4
    push_req(12'h010, 2'b01, 2'b11, 0);
    push_req(12'h012, 2'b01, 2'b11, 2);
    push_done(6'd4, 1'b0, 4);
    start_xfer(12'h010, 6'd4, 2'd1, 2'b01);
    @(posedge CLK); #1;
    chk("t1_working_high", WORKING, 1);
    wait_done("t1");

    // 2: odd start, first pair odd-only, last pair even-only
    push_req(12'h004, 2'b10, 2'b01, 0);
    push_req(12'h006, 2'b10, 2'b11, 2);
    push_req(12'h008, 2'b10, 2'b10, 2);
    push_done(6'd4, 1'b0, 4);
    start_xfer(12'h005, 6'd4, 2'd2, 2'b10);
    wait_done("t2");

    // 3: credit stall, space 2 for 20 cycles
    LSAB_3_SPACE = 6'd2;
    writes_seen = 0; words_req = 0; stall_chk = 1;
    push_req(12'h020, 2'b11, 2'b11, 0);
    push_req(12'h022, 2'b11, 2'b11, 0);
    push_req(12'h024, 2'b11, 2'b11, 0);
    push_done(6'd6, 1'b0, 6);
    start_xfer(12'h020, 6'd6, 2'd3, 2'b11);
    repeat (19) @(posedge CLK);
    #1;
    stall_chk = 0;
    LSAB_3_SPACE = 6'd63;
    wait_done("t3");

    // 4: cancel one cycle after the second request
    push_req(12'h040, 2'b01, 2'b11, 0);
    push_req(12'h042, 2'b01, 2'b11, 2);
    push_done(6'd4, 1'b1, 4);
    start_xfer(12'h040, 6'd10, 2'd0, 2'b01);
    for (int i = 0; i < 50; i++) begin
      if (exp_req_q.size() == 0) break;
      @(posedge CLK); #1;
    end
    chk("t4_second_req_seen", exp_req_q.size(), 0);
    CANCEL = 1'b1;
    @(posedge CLK); #1;
    CANCEL = 1'b0;
    wait_done("t4");

    // 5: zero count
    push_done(6'd0, 1'b0, 0);
    start_xfer(12'h080, 6'd0, 2'd1, 2'b01);
    chk("t5_irq_next_cycle", IRQ_OUT, 1);
    wait_done("t5");

    // 6: reset with data in flight, then a wrapping transfer
    push_req(12'h100, 2'b01, 2'b11, 0);
    start_xfer(12'h100, 6'd8, 2'd1, 2'b01);
    for (int i = 0; i < 50; i++) begin
      if (exp_req_q.size() == 0) break;
      @(posedge CLK); #1;
    end
    chk("t6_first_req_seen", exp_req_q.size(), 0);
    RST = 1'b0;
    #1;
    chk_zero("t6_async_rst");
    due_q.delete(); exp_last_q.delete(); exp_req_q.delete(); exp_done_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (12) @(posedge CLK);
    #1;
    chk("t6_no_irq_after_rst", done_seen, done_mark);
    push_req(12'hFFE, 2'b10, 2'b11, 0);
    push_req(12'h000, 2'b10, 2'b11, 2);
    push_done(6'd4, 1'b0, 4);
    start_xfer(12'hFFE, 6'd4, 2'd2, 2'b10);
    wait_done("t6_wrap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
